ip_blk_engine: RTL and testbench

//  Custom-IP block-move engine in RISC-TOY. Consumes the CONSIG word (register file entry 31).

---
 rtl/ip_blk_engine.sv | 141 ++++++++++++++
 tb/tb_ip_blk_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ip_blk_engine.sv
// Block-move engine: copies or sums LEN words of DATA_RAM starting at SRC and writes the result to DST.
// Latency: copy LEN*(2+RD_LAT), accumulate LEN*(1+RD_LAT)+1 cycles from the start edge to DONE; LEN=0 goes straight to FIN.
// Backpressure: none; it owns DATA_RAM port 2 while BUSY and ignores start edges until it is back in IDLE.
module ip_blk_engine #(
    parameter int BW     = 32,
    parameter int AW     = 10,
    parameter int RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [31:0]   CONSIG,
    input  logic [BW-1:0] MEM_DOUT2,
    output logic          MEM_CSN,
    output logic [1:0]    MEM_WEN,
    output logic [AW-1:0] MEM_A,
    output logic [BW-1:0] MEM_DI2,
    output logic          BUSY,
    output logic          DONE
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam int              WCW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0]  WLAST = WCW'(RD_LAT - 1);
    localparam logic [WCW-1:0]  WONE  = WCW'(1);
    localparam logic [AW-1:0]   ONE   = AW'(1);

    logic [2:0]     state;
    logic           start_q;
    logic           mode_r;
    logic [AW-1:0]  src_r;
    logic [AW-1:0]  dst_r;
    logic [AW-1:0]  len_r;
    logic [AW-1:0]  idx;
    logic [BW-1:0]  acc;
    logic [BW-1:0]  data_r;
    logic [WCW-1:0] wcnt;

    logic start_edge;
    logic last_word;

    assign start_edge = CONSIG[0] & ~start_q;
    // len_r is nonzero in every state that uses this, so the subtraction never underflows.
    assign last_word  = (idx == (len_r - ONE));

    // Sequencer: start-edge detection, field latching, word index, read wait and accumulator.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
            mode_r  <= 1'b0;
            src_r   <= '0;
            dst_r   <= '0;
            len_r   <= '0;
            idx     <= '0;
            acc     <= '0;
            data_r  <= '0;
            wcnt    <= '0;
        end else begin
            start_q <= CONSIG[0];
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        mode_r <= CONSIG[1];
                        src_r  <= CONSIG[11:2];
                        dst_r  <= CONSIG[21:12];
                        len_r  <= CONSIG[31:22];
                        idx    <= '0;
                        acc    <= '0;
                        state  <= (CONSIG[31:22] == 10'd0) ? S_FIN : S_RD;
                    end
                end
                S_RD: begin
                    wcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (wcnt == WLAST) begin
                        data_r <= MEM_DOUT2;
                        if (mode_r) begin
                            acc <= acc + MEM_DOUT2;
                            if (last_word) begin
                                state <= S_WR;
                            end else begin
                                idx   <= idx + ONE;
                                state <= S_RD;
                            end
                        end else begin
                            state <= S_WR;
                        end
                    end else begin
                        wcnt <= wcnt + WONE;
                    end
                end
                S_WR: begin
                    if (mode_r || last_word) begin
                        state <= S_FIN;
                    end else begin
                        idx   <= idx + ONE;
                        state <= S_RD;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM port drive and status decoded from the current state; the RAM is deselected outside RD and WR.
    always_comb begin
        MEM_CSN = 1'b0;
        MEM_WEN = 2'b11;
        MEM_A   = '0;
        MEM_DI2 = '0;
        BUSY    = (state != S_IDLE);
        DONE    = (state == S_FIN);
        case (state)
            S_RD: begin
                MEM_CSN = 1'b1;
                MEM_A   = src_r + idx;
            end
            S_WR: begin
                MEM_CSN = 1'b1;
                MEM_WEN = 2'b01;
                if (mode_r) begin
                    MEM_A   = dst_r;
                    MEM_DI2 = acc;
                end else begin
                    MEM_A   = dst_r + idx;
                    MEM_DI2 = data_r;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ip_blk_engine.sv
// Bench for ip_blk_engine: behavioural DATA_RAM, write scoreboard, DONE/BUSY timing checks.
// Latency: expected DONE cycle derived from LEN, mode and RD_LAT=1.
// Backpressure: none; every wait on the DUT is bounded.
module tb_ip_blk_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] consig;
    logic [31:0] mem_dout2;
    logic        mem_csn;
    logic [1:0]  mem_wen;
    logic [9:0]  mem_a;
    logic [31:0] mem_di2;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb_q[$];
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    ip_blk_engine #(.BW(32), .AW(10), .RD_LAT(1)) dut (
        .CLK       (clk),
        .RST       (rst),
        .CONSIG    (consig),
        .MEM_DOUT2 (mem_dout2),
        .MEM_CSN   (mem_csn),
        .MEM_WEN   (mem_wen),
        .MEM_A     (mem_a),
        .MEM_DI2   (mem_di2),
        .BUSY      (busy),
        .DONE      (done)
    );

    // Synchronous single-port RAM model.
    always @(posedge clk) begin
        if (mem_csn && mem_wen == 2'b01) mem[mem_a] <= mem_di2;
        if (mem_csn && mem_wen == 2'b11) mem_dout2 <= mem[mem_a];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every RAM write must match the next expected write in order.
    always @(negedge clk) begin
        if (mem_csn && mem_wen == 2'b01) begin
            if (sb_q.size() == 0) begin
                chk("wr_unexpected", {54'd0, mem_a}, 64'h3ff_dead);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("wr_addr", {54'd0, mem_a}, {54'd0, e.addr});
                chk("wr_data", {32'd0, mem_di2}, {32'd0, e.data});
            end
        end
    end

    function automatic logic [31:0] mk(input int len, input int dst, input int src, input bit mode);
        mk = {len[9:0], dst[9:0], src[9:0], mode, 1'b1};
    endfunction

    task automatic push_wr(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr[9:0];
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Presents a fresh start edge and measures DONE latency, BUSY length and write count.
    task automatic run_op(input string tag, input logic [31:0] cs, input int exp_lat,
                          input int exp_wr, input bit mid_toggle, input bit expect_no_csn);
        int k, busy_n, wr_n;
        bit csn_seen, got_done;
        k = 0; busy_n = 0; wr_n = 0; csn_seen = 0; got_done = 0;
        @(negedge clk) consig = 32'd0;
        @(negedge clk) consig = cs;
        while (k < 4000 && !got_done) begin
            @(negedge clk);
            k++;
            if (busy) busy_n++;
            if (mem_csn) csn_seen = 1;
            if (mem_csn && mem_wen == 2'b01) wr_n++;
            if (done) got_done = 1;
            if (mid_toggle && k == 2) consig = 32'd0;
            if (mid_toggle && k == 4) consig = mk(2, 500, 16, 1'b0);
        end
        chk({tag, "_done_seen"}, {63'd0, got_done}, 64'd1);
        chk({tag, "_latency"}, k, exp_lat + 1);
        chk({tag, "_busy_cycles"}, busy_n, exp_lat + 1);
        chk({tag, "_writes"}, wr_n, exp_wr);
        if (expect_no_csn) chk({tag, "_csn_seen"}, {63'd0, csn_seen}, 64'd0);
        @(negedge clk);
        chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_idle_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        int hold_busy, rdn;
        bit rst_done_seen;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[16] = 32'd1; mem[17] = 32'd2; mem[18] = 32'd3; mem[19] = 32'd4;
        mem[8] = 32'd5; mem[9] = 32'd7; mem[10] = 32'hFFFF_FFFF;
        mem[1022] = 32'hA1A1_0001; mem[1023] = 32'hA2A2_0002; mem[0] = 32'hA3A3_0003;
        for (int i = 0; i < 8; i++) mem[300 + i] = 32'h300 + i;
        mem_dout2 = 32'd0;
        rst = 1'b1;
        consig = 32'd0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_csn", {63'd0, mem_csn}, 64'd0);
        chk("rst_wen", {62'd0, mem_wen}, 64'd3);
        chk("rst_a", {54'd0, mem_a}, 64'd0);
        chk("rst_di", {32'd0, mem_di2}, 64'd0);
        rst = 1'b0;

        // Copy with a start retrigger while busy.
        push_wr(64, 32'd1); push_wr(65, 32'd2); push_wr(66, 32'd3); push_wr(67, 32'd4);
        run_op("copy", mk(4, 64, 16, 1'b0), 12, 4, 1'b1, 1'b0);

        // START still held high after DONE: no second run.
        hold_busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) hold_busy++;
        end
        chk("hold_busy", hold_busy, 0);

        // Accumulate with overflow, fresh edge with new fields.
        push_wr(100, 32'h0000_000B);
        run_op("acc", mk(3, 100, 8, 1'b1), 7, 1, 1'b0, 1'b0);

        // LEN=0: straight to FIN, RAM untouched.
        run_op("len0", mk(0, 50, 30, 1'b0), 0, 0, 1'b0, 1'b1);

        // Address wrap on the source side.
        push_wr(200, 32'hA1A1_0001); push_wr(201, 32'hA2A2_0002); push_wr(202, 32'hA3A3_0003);
        run_op("wrap", mk(3, 200, 1022, 1'b0), 9, 3, 1'b0, 1'b0);

        // Reset during the third read of an 8-word copy.
        push_wr(400, 32'h300); push_wr(401, 32'h301);
        @(negedge clk) consig = 32'd0;
        @(negedge clk) consig = mk(8, 400, 300, 1'b0);
        rdn = 0;
        rst_done_seen = 0;
        for (int k = 0; k < 200 && rdn < 3; k++) begin
            @(negedge clk);
            if (done) rst_done_seen = 1;
            if (mem_csn && mem_wen == 2'b11) rdn++;
        end
        chk("mid_rd_count", rdn, 3);
        rst = 1'b1;
        consig = 32'd0;
        @(negedge clk);
        chk("mid_busy", {63'd0, busy}, 64'd0);
        chk("mid_done", {63'd0, done}, 64'd0);
        chk("mid_csn", {63'd0, mem_csn}, 64'd0);
        chk("mid_wen", {62'd0, mem_wen}, 64'd3);
        chk("mid_a", {54'd0, mem_a}, 64'd0);
        chk("mid_di", {32'd0, mem_di2}, 64'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) rst_done_seen = 1;
        end
        chk("mid_no_done", {63'd0, rst_done_seen}, 64'd0);
        chk("mid_sb_empty", sb_q.size(), 0);
        chk("mid_unwritten", {32'd0, mem[402]}, 64'd0);

        // Engine recovers after the abandoned run.
        push_wr(600, 32'd1);
        run_op("after_rst", mk(1, 600, 16, 1'b0), 3, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
